// File: rtl/parallel_to_serial_pkg.sv
// -----------------------------------------------------------------------------
// parallel_to_serial_pkg
// Shared definitions for the serial link transmitter and its matching
// receiver: frame length, bit-counter width and the transmitter state set.
// No ports; imported by parallel_to_serial.
// -----------------------------------------------------------------------------
package parallel_to_serial_pkg;

    // Number of bits in one serial frame; the receiver decodes the same count.
    localparam int FRAME_BITS = 15;

    // Bit counter is wide enough to index every bit of a frame.
    localparam int BIT_CNT_W = 4;

    // Index of the final bit in a frame, pre-sized for bit-counter compares.
    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(FRAME_BITS - 1);

    // Transmitter states: waiting for a word, serial clock low, serial clock
    // high, and the idle spacing between frames.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/bit_timer.sv
// -----------------------------------------------------------------------------
// bit_timer
// Phase timer for the serial clock. Counts system-clock cycles while enabled
// and flags the last cycle of a HALF_PERIOD-long phase so the owner can switch
// phase on the following edge.
//
// Ports:
//   clk        system clock
//   reset      synchronous, active-high reset
//   restart_i  clear the count on the next edge (start of a new phase)
//   enable_i   a phase is in progress; count this cycle
//   tc_o       terminal count: this is the final cycle of the current phase
// -----------------------------------------------------------------------------
module bit_timer #(
    parameter int HALF_PERIOD = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic restart_i,
    input  logic enable_i,
    output logic tc_o
);

    localparam int PW = $clog2(HALF_PERIOD + 1);
    localparam logic [PW-1:0] LAST_COUNT = PW'(HALF_PERIOD - 1);

    logic [PW-1:0] count_q;
    logic [PW-1:0] count_d;

    // Restart wins over counting so a new phase always begins at zero. The
    // owner restarts on every terminal count, so the counter never passes
    // LAST_COUNT and never wraps.
    always_comb begin
        count_d = count_q;
        if (restart_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + PW'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Terminal count is only meaningful while a phase is running.
    assign tc_o = enable_i && (count_q == LAST_COUNT);

endmodule

// File: rtl/parallel_to_serial.sv
// -----------------------------------------------------------------------------
// parallel_to_serial
// Accepts a 15-bit word over a valid/ready handshake and sends it MSB first as
// a bit-serial frame on a generated serial clock/data pair. Each bit spends
// HALF_PERIOD cycles with the serial clock low (data set up) and HALF_PERIOD
// cycles high (receiver samples on the rising edge). GAP_CYCLES idle cycles
// follow each frame before the next word is accepted.
//
// Ports:
//   clk           system clock (only clock)
//   reset         synchronous, active-high reset
//   data_in       parallel word to send
//   in_valid      data_in is valid
//   in_ready      block can accept a word (idle)
//   serial_clock  generated serial clock, idles low
//   serial_data   serial data, MSB first, 0 when not sending
//   busy          frame or inter-frame gap in progress
//   done          one-cycle pulse when the last bit's high phase ends
// -----------------------------------------------------------------------------
module parallel_to_serial
    import parallel_to_serial_pkg::*;
#(
    parameter int HALF_PERIOD = 4,
    parameter int GAP_CYCLES  = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [FRAME_BITS-1:0] data_in,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_clock,
    output logic                  serial_data,
    output logic                  busy,
    output logic                  done
);

    // A zero-length gap still needs a 1-bit counter to keep widths legal; the
    // GAP state is simply never entered in that case.
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [GAP_W-1:0] GAP_LAST =
        GAP_W'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

    state_e                 state_q, state_d;
    logic [FRAME_BITS-1:0]  shift_q, shift_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
    logic                   sclk_q, sclk_d;
    logic                   sdata_q, sdata_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    logic                   accept;
    logic                   phase_active;
    logic                   phase_tc;

    assign accept       = in_valid && (state_q == IDLE);
    assign phase_active = (state_q == LOW) || (state_q == HIGH);

    // The phase timer is restarted whenever a word is taken or a phase ends,
    // so every LOW and HIGH phase lasts exactly HALF_PERIOD cycles.
    bit_timer #(
        .HALF_PERIOD (HALF_PERIOD)
    ) u_bit_timer (
        .clk       (clk),
        .reset     (reset),
        .restart_i (accept || phase_tc),
        .enable_i  (phase_active),
        .tc_o      (phase_tc)
    );

    // Next-state logic. The shift register only moves on the HIGH->LOW
    // transition, so serial data changes together with the falling serial
    // clock and is stable for a full phase on either side of the rising edge.
    // The outputs are computed from the next state so that every output is a
    // plain register with no path from the inputs.
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        done_d    = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    shift_d   = data_in;
                    bit_cnt_d = '0;
                    state_d   = LOW;
                end
            end
            LOW: begin
                if (phase_tc) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (phase_tc) begin
                    if (bit_cnt_q == LAST_BIT) begin
                        done_d    = 1'b1;
                        gap_cnt_d = '0;
                        state_d   = (GAP_CYCLES == 0) ? IDLE : GAP;
                    end else begin
                        shift_d   = {shift_q[FRAME_BITS-2:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        state_d   = LOW;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        sclk_d  = (state_d == HIGH);
        sdata_d = ((state_d == LOW) || (state_d == HIGH)) ?
                  shift_d[FRAME_BITS-1] : 1'b0;
        ready_d = (state_d == IDLE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers. Reset takes priority over a handshake and
    // aborts any frame in flight without a done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
            sclk_q    <= 1'b0;
            sdata_q   <= 1'b0;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
            sclk_q    <= sclk_d;
            sdata_q   <= sdata_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign in_ready     = ready_q;
    assign serial_clock = sclk_q;
    assign serial_data  = sdata_q;
    assign busy         = busy_q;
    assign done         = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// -----------------------------------------------------------------------------
// tb_parallel_to_serial
// Two transmitters share clock and reset: lane 0 with HALF_PERIOD=2,
// GAP_CYCLES=3 and lane 1 with HALF_PERIOD=1, GAP_CYCLES=0. Stimulus pushes
// the words that should appear on the wire into a per-lane queue; a per-lane
// receiver model decodes frames from serial_clock/serial_data, checks edge and
// handshake timing, and pops the queue on every done pulse.
// -----------------------------------------------------------------------------
module tb_parallel_to_serial;

    logic        clk = 1'b0;
    logic        reset;
    logic [14:0] dataIn      [2];
    logic        inValid     [2];
    logic        inReady     [2];
    logic        serialClock [2];
    logic        serialData  [2];
    logic        busy        [2];
    logic        done        [2];

    int          asserts = 0;
    int          errors  = 0;
    logic [14:0] expQ0[$];
    logic [14:0] expQ1[$];
    bit          b2bCheck [2];

    // Free-running system clock.
    always #5 clk = ~clk;

    parallel_to_serial #(
        .HALF_PERIOD (2),
        .GAP_CYCLES  (3)
    ) dutA (
        .clk          (clk),
        .reset        (reset),
        .data_in      (dataIn[0]),
        .in_valid     (inValid[0]),
        .in_ready     (inReady[0]),
        .serial_clock (serialClock[0]),
        .serial_data  (serialData[0]),
        .busy         (busy[0]),
        .done         (done[0])
    );

    parallel_to_serial #(
        .HALF_PERIOD (1),
        .GAP_CYCLES  (0)
    ) dutB (
        .clk          (clk),
        .reset        (reset),
        .data_in      (dataIn[1]),
        .in_valid     (inValid[1]),
        .in_ready     (inReady[1]),
        .serial_clock (serialClock[1]),
        .serial_data  (serialData[1]),
        .busy         (busy[1]),
        .done         (done[1])
    );

    // Single comparison point: every check is counted and reported here.
    task automatic checkOutput(input string name, input int ln,
                               input logic [31:0] actual,
                               input logic [31:0] expected);
        asserts++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s (lane %0d): got %0h, expected %0h",
                     name, ln, actual, expected);
        end
    endtask

    // Per-lane queue helpers.
    task automatic pushExp(input int ln, input logic [14:0] w);
        if (ln == 0) expQ0.push_back(w);
        else         expQ1.push_back(w);
    endtask

    function automatic int qDepth(input int ln);
        return (ln == 0) ? expQ0.size() : expQ1.size();
    endfunction

    function automatic logic [14:0] qPop(input int ln);
        if (ln == 0) return expQ0.pop_front();
        return expQ1.pop_front();
    endfunction

    // Present a word and hold valid until the lane accepts it. When the word
    // is expected on the wire it is queued for the receiver model first.
    task automatic applyStimulus(input int ln, input logic [14:0] w,
                                 input bit expectSent);
        bit accepted;
        accepted = 1'b0;
        if (expectSent) pushExp(ln, w);
        dataIn[ln]  = w;
        inValid[ln] = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (inReady[ln] === 1'b1) begin
                accepted = 1'b1;
                break;
            end
        end
        @(posedge clk);
        #1;
        inValid[ln] = 1'b0;
        if (!accepted) checkOutput("accept timeout", ln, 32'd0, 32'd1);
    endtask

    // Wait until every queued frame has been received and the lane is idle.
    task automatic waitIdle(input int ln);
        bit idle;
        idle = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (qDepth(ln) == 0 && inReady[ln] === 1'b1) begin
                idle = 1'b1;
                break;
            end
        end
        if (!idle) checkOutput("idle timeout", ln, 32'd0, 32'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Receiver model and timing monitor, one per lane. rel is the cycle
    // number relative to the most recent accepting edge (that edge is 0).
    for (genvar g = 0; g < 2; g++) begin : mon
        localparam int H = (g == 0) ? 2 : 1;
        localparam int G = (g == 0) ? 3 : 0;

        int          rel       = 0;
        bit          rstAtEdge = 1'b0;
        int          bitIdx    = 0;
        logic [14:0] shiftIn   = '0;
        logic        prevClk   = 1'b0;
        logic        prevReady = 1'b1;
        logic [14:0] expWord;

        // Track handshakes and reset at the active edge.
        always @(posedge clk) begin
            rstAtEdge <= reset;
            if (reset) begin
                rel <= 0;
            end else if (inValid[g] === 1'b1 && inReady[g] === 1'b1) begin
                if (b2bCheck[g])
                    checkOutput("accept cycle", g, 32'(rel), 32'(30*H + G + 1));
                rel <= 1;
            end else begin
                rel <= rel + 1;
            end
        end

        // Decode the serial stream and check timing away from the active edge.
        always @(negedge clk) begin
            if (rstAtEdge) begin
                checkOutput("reset serial_clock", g, 32'(serialClock[g]), 32'd0);
                checkOutput("reset serial_data",  g, 32'(serialData[g]),  32'd0);
                checkOutput("reset in_ready",     g, 32'(inReady[g]),     32'd1);
                checkOutput("reset busy",         g, 32'(busy[g]),        32'd0);
                checkOutput("reset done",         g, 32'(done[g]),        32'd0);
                bitIdx  = 0;
                shiftIn = '0;
            end else begin
                if (serialClock[g] === 1'b1 && prevClk === 1'b0) begin
                    checkOutput("rise cycle", g, 32'(rel),
                                32'(2*H*bitIdx + H + 1));
                    shiftIn = {shiftIn[13:0], serialData[g]};
                    bitIdx++;
                end
                if (done[g] !== 1'b0) begin
                    checkOutput("done cycle", g, 32'(rel), 32'(30*H + 1));
                    checkOutput("bits per frame", g, 32'(bitIdx), 32'd15);
                    checkOutput("frame expected", g, 32'(qDepth(g) > 0), 32'd1);
                    if (qDepth(g) > 0) begin
                        expWord = qPop(g);
                        checkOutput("decoded word", g, 32'(shiftIn), 32'(expWord));
                    end
                    bitIdx = 0;
                end
                if (inReady[g] === 1'b1 && prevReady === 1'b0)
                    checkOutput("ready cycle", g, 32'(rel), 32'(30*H + G + 1));
            end
            prevClk   = serialClock[g];
            prevReady = inReady[g];
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, asserts=%0d errors=%0d",
                 asserts, errors);
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed sequence.
    initial begin
        reset       = 1'b1;
        inValid[0]  = 1'b0;
        inValid[1]  = 1'b0;
        dataIn[0]   = '0;
        dataIn[1]   = '0;
        b2bCheck[0] = 1'b0;
        b2bCheck[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("[TB] single frame 15'h5A3C");
        applyStimulus(0, 15'h5A3C, 1'b1);
        waitIdle(0);

        $display("[TB] back-to-back 15'h7FFF, 15'h0001");
        applyStimulus(0, 15'h7FFF, 1'b1);
        b2bCheck[0] = 1'b1;
        applyStimulus(0, 15'h0001, 1'b1);
        b2bCheck[0] = 1'b0;
        waitIdle(0);

        $display("[TB] ignored input during 15'h0F0F");
        applyStimulus(0, 15'h0F0F, 1'b1);
        repeat (20) @(posedge clk);
        #1;
        dataIn[0]  = 15'h1234;
        inValid[0] = 1'b1;
        @(posedge clk);
        #1;
        inValid[0] = 1'b0;
        waitIdle(0);
        repeat (80) @(posedge clk);
        #1;

        $display("[TB] reset during bit 6, then 15'h2AAA");
        applyStimulus(0, 15'h3333, 1'b0);
        repeat (25) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        applyStimulus(0, 15'h2AAA, 1'b1);
        waitIdle(0);

        $display("[TB] loopback, 16 words");
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 15'($urandom), 1'b1);
            if (i == 0) b2bCheck[1] = 1'b1;
        end
        b2bCheck[1] = 1'b0;
        waitIdle(1);

        checkOutput("leftover frames", 0, 32'(qDepth(0)), 32'd0);
        checkOutput("leftover frames", 1, 32'(qDepth(1)), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 asserts, errors);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side counterpart of the serial-to-parallel receiver: accepts a 15-bit parallel word over a valid/ready handshake. It then emits the word as a bit-serial frame on a generated serial clock and data pair, in the format the receiver's `serial_clock`/`serial_data` inputs consume. It sits in a companion tile or test harness that drives the receiver.

## Interface
- `HALF_PERIOD`, default 4: system-clock cycles per serial-clock phase (low or high); legal range ≥ 1.
- `GAP_CYCLES`, default 2: idle cycles after each frame before the next word is accepted; legal range ≥ 0.
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `data_in`  in  15  parallel word to send.
- `in_valid`  in  1  `data_in` is valid.
- `in_ready`  out  1  block can accept a word.
- `serial_clock`  out  1  generated serial clock; idles low.
- `serial_data`  out  1  serial data, MSB (`data_in[14]`) first.
- `busy`  out  1  frame or gap in progress.
- `done`  out  1  one-cycle pulse when the last bit's high phase ends.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - LOW: `serial_clock`=0, data set up.
  - HIGH: `serial_clock`=1, receiver samples on the rising edge.
  - GAP: inter-frame idle.
- Transfer: a word is accepted on any edge with `in_valid && in_ready`. On that edge `data_in` is latched into a 15-bit shift register, the bit counter is cleared to 0, and the block enters LOW.
- LOW: `serial_data` = shift_reg[14]. After HALF_PERIOD cycles, go to HIGH.
- HIGH, after HALF_PERIOD cycles:
  - Bit counter < 14: shift left by 1, increment the counter, go to LOW. Data therefore changes only together with the falling edge.
  - Bit counter = 14: go to GAP, or to IDLE if GAP_CYCLES = 0. Pulse `done` for that first cycle.
- GAP: hold for GAP_CYCLES cycles, then go to IDLE.
- `serial_data` is 0 in IDLE and GAP.
- `busy` = not IDLE. `in_ready` = IDLE.
- `in_valid` while not IDLE is ignored. The word is not queued, and `data_in` is not sampled after acceptance.
- Reset values: state IDLE, `serial_clock`=0, `serial_data`=0, `in_ready`=1, `busy`=0, `done`=0, shift register 0, counters 0.
- Reset mid-frame: on the next edge the block aborts to IDLE with the reset values, emits no `done`, and leaves the partial frame truncated.
- Reset has priority over a simultaneous handshake.
- Phase counter width is $clog2(HALF_PERIOD+1), gap counter width is $clog2(GAP_CYCLES+1), and the bit counter is 4 bits. All counters are compared for equality and never wrap.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- Define cycle 0 as the accepting edge. Then:
  - Cycles 1..H: LOW, `serial_data` = bit14.
  - Cycles H+1..2H: HIGH, so the rising edge is visible at cycle H+1.
  - Bit k (k = 0..14, counting from the MSB) occupies cycles 2Hk+1..2H(k+1).
  - The frame is 30H cycles long.
- `done` is high in cycle 30H+1, the same cycle `serial_clock` returns low.
- `in_ready` rises in cycle 30H+G+1, where G = GAP_CYCLES. With G=0, `done` and `in_ready` rise in the same cycle.
- Back-to-back throughput is one word per 30H+G+1 cycles.
- Data setup and hold relative to the serial-clock rising edge are both H system cycles.

## Structure
- Shared package holds:
  - `FRAME_BITS` = 15, which the receiver also uses.
  - The state enum {IDLE, LOW, HIGH, GAP}.
  - The bit-counter width localparam.
- One sub-module is natural: `bit_timer`, a phase counter with a HALF_PERIOD terminal-count pulse and synchronous restart.
- The shift register, bit counter, gap counter and FSM stay in `parallel_to_serial`.

## Test plan
- Reset: hold `reset` for 3 cycles. Require `serial_clock`=0, `serial_data`=0, `in_ready`=1, `busy`=0, `done`=0.
- Single frame, H=2, G=3, `data_in`=15'h5A3C: require 15 rising edges at cycles 3, 7, …, 59, and data sampled at those edges = 101101000111100. Require `done` at cycle 61 only and `in_ready` at cycle 64.
- Back-to-back: hold `in_valid` with words 15'h7FFF then 15'h0001. Require the second acceptance exactly at the `in_ready` cycle, the second frame to start with no extra gap, and each frame to decode correctly.
- Ignored input: pulse `in_valid` with 15'h1234 in the middle of the 15'h0F0F frame. Require 15'h0F0F to be sent unaltered and no second frame.
- Reset mid-frame: assert `reset` during bit 6. Require IDLE with `serial_clock`=0 on the next edge and no `done`. Require the next word (15'h2AAA) to be sent correctly.
- Loopback: connect to the receiver via `serial_clock`/`serial_data`, with H=1 and G=0 on 16 random words. Require the receiver's `data_out` to equal each sent word when its `data_ready` asserts.
